core88_membridge: RTL

- Memory responder for the core88 byte bus.
- Accepts the core's 20-bit byte address, write data and write request, and returns read bytes on `bus`.
- Drives `locked` to stall the core until each access completes.
- Bridges to a 16-bit word-wide backend memory using a req/ack handshake, with a one-word read buffer so consecutive bytes of one word are served without a backend access.

---
 rtl/core88_pkg.sv | 15 +
 rtl/core88_wbuf.sv | 44 ++++
 rtl/core88_membridge.sv | 110 +++++++++++
 3 files changed

// File: rtl/core88_pkg.sv
// core88_pkg: shared encodings for the core88 memory bridge.
package core88_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RWAIT = 2'd1,
      WWAIT = 2'd2,
      WDONE = 2'd3
   } state_t;

   localparam logic [1:0] BE_LO = 2'b01;
   localparam logic [1:0] BE_HI = 2'b10;
   localparam logic [1:0] BE_W  = 2'b11;

endpackage

// File: rtl/core88_wbuf.sv
// core88_wbuf: one-word read buffer with fill, write-through byte merge and byte-select hit port.
module core88_wbuf #(
   parameter int EN = 1,
   parameter int TW = 19
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          i_fill,
   input  logic [TW-1:0] i_fill_tag,
   input  logic [15:0]   i_fill_data,
   input  logic          i_merge,
   input  logic [TW-1:0] i_merge_tag,
   input  logic [1:0]    i_merge_be,
   input  logic [15:0]   i_merge_data,
   input  logic [TW:0]   i_lookup,
   output logic          o_hit,
   output logic [7:0]    o_byte
);

   logic          r_valid;
   logic [TW-1:0] r_tag;
   logic [15:0]   r_data;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_valid <= 1'b0;
         r_tag   <= '0;
         r_data  <= '0;
      end else if (i_fill) begin
         r_valid <= 1'b1;
         r_tag   <= i_fill_tag;
         r_data  <= i_fill_data;
      end else if (i_merge && r_valid && r_tag == i_merge_tag) begin
         if (i_merge_be[0]) r_data[7:0]  <= i_merge_data[7:0];
         if (i_merge_be[1]) r_data[15:8] <= i_merge_data[15:8];
      end
   end

   always_comb begin
      o_hit  = (EN != 0) && r_valid && r_tag == i_lookup[TW:1];
      o_byte = i_lookup[0] ? r_data[15:8] : r_data[7:0];
   end

endmodule

// File: rtl/core88_membridge.sv
// core88_membridge: core88 byte bus responder bridging to a 16-bit req/ack backend,
// stalling the core with locked until each access completes.
module core88_membridge
   import core88_pkg::*;
#(
   parameter int BUF_EN = 1,
   parameter int AW     = 20
) (
   input  logic          clock,
   input  logic          reset,
   input  logic [AW-1:0] address,
   input  logic [7:0]    data,
   input  logic          wreq,
   output logic [7:0]    bus,
   output logic          locked,
   output logic          mem_req,
   output logic          mem_we,
   output logic [AW-2:0] mem_addr,
   output logic [1:0]    mem_be,
   output logic [15:0]   mem_wdata,
   input  logic          mem_ack,
   input  logic [15:0]   mem_rdata
);

   state_t        r_state, w_next_state;
   logic          r_mem_req, r_mem_we, r_byp;
   logic [1:0]    r_mem_be;
   logic [AW-2:0] r_mem_addr;
   logic [15:0]   r_mem_wdata, r_byp_data;
   logic          w_hit, w_serve, w_idle, w_ack_r, w_ack_w;
   logic [7:0]    w_buf_byte;

   assign w_idle  = r_state == IDLE;
   assign w_ack_r = r_state == RWAIT && mem_ack;
   assign w_ack_w = r_state == WWAIT && mem_ack;
   assign w_serve = w_idle && !wreq && (w_hit || r_byp);

   core88_wbuf #(.EN(BUF_EN), .TW(AW-1)) u_wbuf (
      .clock        (clock),
      .reset        (reset),
      .i_fill       (w_ack_r),
      .i_fill_tag   (r_mem_addr),
      .i_fill_data  (mem_rdata),
      .i_merge      (w_ack_w),
      .i_merge_tag  (r_mem_addr),
      .i_merge_be   (r_mem_be),
      .i_merge_data (r_mem_wdata),
      .i_lookup     (address),
      .o_hit        (w_hit),
      .o_byte       (w_buf_byte)
   );

   always_ff @(posedge clock) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:    w_next_state = wreq ? WWAIT : (w_hit || r_byp) ? IDLE : RWAIT;
         RWAIT:   w_next_state = mem_ack ? IDLE : RWAIT;
         WWAIT:   w_next_state = mem_ack ? WDONE : WWAIT;
         default: w_next_state = IDLE;
      endcase
   end

   // Backend handshake registers; the bypass flag presents an unbuffered fill exactly once.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_be    <= '0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_byp       <= 1'b0;
         r_byp_data  <= '0;
      end else begin
         r_byp <= (BUF_EN == 0) && w_ack_r;
         if (w_ack_r) r_byp_data <= mem_rdata;
         if (w_idle && wreq) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b1;
            r_mem_addr  <= address[AW-1:1];
            r_mem_be    <= address[0] ? BE_HI : BE_LO;
            r_mem_wdata <= {data, data};
         end else if (w_idle && !w_serve) begin
            r_mem_req  <= 1'b1;
            r_mem_we   <= 1'b0;
            r_mem_addr <= address[AW-1:1];
            r_mem_be   <= BE_W;
         end else if (w_ack_r || w_ack_w) begin
            r_mem_req <= 1'b0;
         end
      end
   end

   always_comb begin
      locked = !reset && (w_serve || r_state == WDONE);
      bus    = (!reset && w_serve) ?
               (r_byp ? (address[0] ? r_byp_data[15:8] : r_byp_data[7:0]) : w_buf_byte) : 8'h00;
   end

   assign mem_req   = r_mem_req;
   assign mem_we    = r_mem_we;
   assign mem_addr  = r_mem_addr;
   assign mem_be    = r_mem_be;
   assign mem_wdata = r_mem_wdata;

endmodule
